// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. A start pulse loads both operands in parallel.
//   A single full-adder cell and a carry flip-flop then produce one sum bit
//   per clock, LSB first. After WIDTH bits the parallel sum and carry-out are
//   written together, and done pulses for one cycle.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; only sampled in IDLE or DONE
//   a, b   in   WIDTH  operands, captured in the cycle start is accepted
//   busy   out  1      high while bits are being produced (RUN)
//   done   out  1      one-cycle pulse: sum/cout were just updated
//   sum    out  WIDTH  registered result, updated only on completion
//   cout   out  1      registered carry-out of the MSB
//   sbit   out  1      current serial sum bit (debug), 0 outside RUN
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sbit
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Carry of a full-adder cell.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;

  logic               bit_s;
  logic               carry_next_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic               last_s;
  logic               load_s;
  logic               step_s;
  logic               finish_s;
  logic               sbit_s;

  // Full-adder cell on the operand LSBs and the partial result after this bit.
  always_comb begin
    bit_s        = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    carry_next_s = majority(a_sh_r[0], b_sh_r[0], carry_r);
    acc_next_s   = {bit_s, acc_r[WIDTH-1:1]};
    last_s       = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here: no restart, no queueing.
        step_s = 1'b1;
        if (last_s) begin
          finish_s     = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Debug serial bit, forced low whenever no addition is running.
  always_comb begin
    if (state_r == ST_RUN) begin
      sbit_s = bit_s;
    end else begin
      sbit_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand shifters, carry flip-flop, bit counter and partial-sum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (step_s) begin
      a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
      acc_r   <= acc_next_s;
      carry_r <= carry_next_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  // Result registers: written only with the final bit, so no partial value leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (finish_s) begin
      sum_r  <= acc_next_s;
      cout_r <= carry_next_s;
    end
  end

  // Status flags registered from the next state so they align with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_RUN);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign sbit = sbit_s;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Expected results come from
//   plain arithmetic (a+b as a WIDTH+1 bit value) and the stated latency.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         sbit;

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .sbit  (sbit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one addition from IDLE and follow it to done.
  // done_k: negedge index (1 = first after the accept edge) where done was seen, -1 on timeout.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int done_k, output int busy_cnt,
                        output logic [W-1:0] sbits, output logic stable);
    logic [W-1:0] held_sum;
    logic         held_cout;
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    held_sum  = sum;
    held_cout = cout;
    @(negedge clk);
    start    = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    done_k   = -1;
    busy_cnt = 0;
    sbits    = '0;
    stable   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      if ((sum !== held_sum) || (cout !== held_cout)) stable = 1'b0;
      if (busy === 1'b1) begin
        if (busy_cnt < W) sbits[busy_cnt] = sbit;
        busy_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, sbit} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b sbit=%b required all 0",
               busy, done, sum, cout, sbit);
    end
  endtask

  task automatic test_zero();
    int dk, bc;
    logic [W-1:0] sb;
    logic st;
    run_op(8'h00, 8'h00, dk, bc, sb, st);
    checks++;
    if (dk !== 9) begin
      failures++;
      $display("FAIL zero_latency: done at cycle %0d required 9", dk);
    end
    checks++;
    if (bc !== 8) begin
      failures++;
      $display("FAIL zero_busy: busy cycles %0d required 8", bc);
    end
    checks++;
    if ({cout, sum} !== 9'h000) begin
      failures++;
      $display("FAIL zero_sum: cout/sum=%b/%h required 0/00", cout, sum);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL done_one_cycle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_sbit();
    int dk, bc;
    logic [W-1:0] sb;
    logic st;
    run_op(8'h0F, 8'h01, dk, bc, sb, st);
    checks++;
    if ({cout, sum} !== 9'h010) begin
      failures++;
      $display("FAIL sbit_sum: cout/sum=%b/%h required 0/10", cout, sum);
    end
    checks++;
    if (sb !== 8'h10) begin
      failures++;
      $display("FAIL sbit_seq: lsb-first bits=%b required 00010000 (msb..lsb)", sb);
    end
    @(negedge clk);
    checks++;
    if (sbit !== 1'b0) begin
      failures++;
      $display("FAIL sbit_idle: sbit=%b required 0", sbit);
    end
  endtask

  task automatic test_carry();
    int dk, bc;
    logic [W-1:0] sb;
    logic st;
    run_op(8'hFF, 8'h01, dk, bc, sb, st);
    checks++;
    if ({cout, sum} !== 9'h100) begin
      failures++;
      $display("FAIL carry_ripple: cout/sum=%b/%h required 1/00", cout, sum);
    end
    run_op(8'hFF, 8'hFF, dk, bc, sb, st);
    checks++;
    if ({cout, sum} !== 9'h1FE) begin
      failures++;
      $display("FAIL carry_max: cout/sum=%b/%h required 1/fe", cout, sum);
    end
    checks++;
    if (st !== 1'b1) begin
      failures++;
      $display("FAIL carry_hold: result changed before done (stable=%b) required 1", st);
    end
  endtask

  task automatic test_back_to_back();
    int dk;
    @(negedge clk);
    a_in  = 8'h12;
    b_in  = 8'h34;
    start = 1'b1;
    @(negedge clk);
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        dk = k;
        break;
      end
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      start = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (dk !== 9) begin
      failures++;
      $display("FAIL ignore_start_latency: done at cycle %0d required 9", dk);
    end
    checks++;
    if ({cout, sum} !== 9'h046) begin
      failures++;
      $display("FAIL ignore_start_sum: cout/sum=%b/%h required 0/46", cout, sum);
    end
    // Still in the DONE cycle: start stays high with new operands.
    a_in  = 8'h80;
    b_in  = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL restart_immediate: busy=%b done=%b required 1 0", busy, done);
    end
    dk = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        dk = k;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (dk !== 9) begin
      failures++;
      $display("FAIL restart_latency: done at cycle %0d required 9", dk);
    end
    checks++;
    if ({cout, sum} !== 9'h100) begin
      failures++;
      $display("FAIL restart_sum: cout/sum=%b/%h required 1/00", cout, sum);
    end
  endtask

  task automatic test_reset_midop();
    int dk, bc;
    logic [W-1:0] sb;
    logic st;
    run_op(8'h33, 8'h44, dk, bc, sb, st);
    checks++;
    if ({cout, sum} !== 9'h077) begin
      failures++;
      $display("FAIL pre_reset_sum: cout/sum=%b/%h required 0/77", cout, sum);
    end
    @(negedge clk);
    a_in  = 8'hAA;
    b_in  = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midop_busy: busy=%b required 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
               busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h02, dk, bc, sb, st);
    checks++;
    if ((dk !== 9) || ({cout, sum} !== 9'h003)) begin
      failures++;
      $display("FAIL after_reset: done at %0d cout/sum=%b/%h required 9 0/03", dk, cout, sum);
    end
  endtask

  task automatic test_random();
    int dk, bc;
    logic [W-1:0] sb;
    logic st;
    logic [W-1:0] av, bv;
    logic [W:0]   expv;
    for (int i = 0; i < 1000; i++) begin
      av   = W'($urandom);
      bv   = W'($urandom);
      expv = {1'b0, av} + {1'b0, bv};
      run_op(av, bv, dk, bc, sb, st);
      checks++;
      if ({cout, sum} !== expv) begin
        failures++;
        $display("FAIL rand_sum: %h+%h cout/sum=%b/%h required %b/%h",
                 av, bv, cout, sum, expv[W], expv[W-1:0]);
      end
      checks++;
      if ((dk !== 9) || (bc !== 8) || (st !== 1'b1)) begin
        failures++;
        $display("FAIL rand_timing: %h+%h done_at=%0d busy=%0d stable=%b required 9 8 1",
                 av, bv, dk, bc, st);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero();
    test_sbit();
    test_carry();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
